alu_result_fifo: RTL

- Downstream capture stage for the combinational ALU.
- Registers each ALU result with its flags and opcode into a small in-order FIFO.
- Presents buffered entries to the consumer (writeback or trace logic) over a valid/ready handshake.
- Decouples the ALU's zero-latency output from a consumer that may stall.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_result_fifo.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode type shared by the ALU and its result capture stage
package alu_pkg;

  typedef enum logic [2:0] {
    ADD,
    SUB,
    AND,
    OR,
    XOR,
    SHIFT_LEFT,
    SHIFT_RIGHT
  } alu_op_t;

  localparam int ALU_OP_W = $bits(alu_op_t);

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - in-order show-ahead FIFO capturing ALU result, flags and opcode
// Optional ALU_RESULT_STATS_EN adds saturating zero/carry counters on accepted pushes.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_result,
  input  logic                       in_carry,
  input  logic                       in_zero,
  input  alu_op_t                    in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_result,
  output logic                       out_carry,
  output logic                       out_zero,
  output alu_op_t                    out_op,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]                zero_cnt,
  output logic [15:0]                carry_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = ALU_OP_W + 2 + N;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // Readiness comes from the registered level only, so a same-cycle pop never frees a slot.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready && !clear;
  assign pop       = out_valid && out_ready && !clear;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_carry, in_zero, in_result};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Head fields are masked while empty so stale storage never leaks to the consumer.
  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head[N-1:0] : '0;
  assign out_zero   = out_valid ? head[N] : 1'b0;
  assign out_carry  = out_valid ? head[N+1] : 1'b0;
  assign out_op     = out_valid ? alu_op_t'(head[EW-1 -: ALU_OP_W]) : ADD;

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt  <= '0;
      carry_cnt <= '0;
    end else if (clear) begin
      zero_cnt  <= '0;
      carry_cnt <= '0;
    end else begin
      if (push && in_zero && (zero_cnt != 16'hFFFF)) begin
        zero_cnt <= zero_cnt + 16'd1;
      end
      if (push && in_carry && (carry_cnt != 16'hFFFF)) begin
        carry_cnt <= carry_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
